// File: rtl/conv_pkg.sv
// Shared types and fixed-point helpers for post-convolution requantisation stages.
package conv_pkg;

    typedef enum logic [1:0] {
        ACT_BYPASS = 2'b00,
        ACT_RELU   = 2'b01,
        ACT_LEAKY  = 2'b10
    } act_mode_e;

    typedef enum logic {StIdle, StRun} state_e;

    // Wide enough for any accumulator plus rounding offset these stages handle.
    localparam int unsigned CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Round-half-up arithmetic right shift.
    function automatic calc_t round_shift(input calc_t a, input int unsigned sh);
        calc_t half;
        half = (sh == 0) ? calc_t'(0) : (calc_t'(1) <<< (sh - 1));
        return (a + half) >>> sh;
    endfunction

    function automatic calc_t sat_max(input int unsigned w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t sat_min(input int unsigned w);
        return -(calc_t'(1) <<< (w - 1));
    endfunction

    function automatic logic is_sat(input calc_t v, input int unsigned w);
        return (v > sat_max(w)) || (v < sat_min(w));
    endfunction

    function automatic calc_t saturate(input calc_t v, input int unsigned w);
        if (v > sat_max(w)) return sat_max(w);
        if (v < sat_min(w)) return sat_min(w);
        return v;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous flush and occupancy count; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
        end
    end

    // Empty FIFO presents zero so the head is clean after reset or flush.
    assign rd_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign count   = count_q;

endmodule

// File: rtl/conv_act_requant.sv
// Post-convolution stage: bias, activation, rounding requant shift, saturation, output FIFO.
module conv_act_requant
    import conv_pkg::*;
#(
    parameter int unsigned ACC_W       = 22,
    parameter int unsigned OUT_W       = 8,
    parameter int unsigned SHIFT_W     = 5,
    parameter int unsigned LEAKY_SHIFT = 3,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned LEN_W       = 16,
    parameter int unsigned SAT_W       = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_signal,
    input  logic [1:0]         mode,
    input  logic [ACC_W-1:0]   bias,
    input  logic [SHIFT_W-1:0] shift,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               done_signal,
    output logic               busy,
    output logic [SAT_W-1:0]   sat_count
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    state_e                   state_q, state_d;
    act_mode_e                mode_q;
    logic [ACC_W-1:0]         bias_q;
    logic [SHIFT_W-1:0]       shift_q;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         acc_cnt_q;
    logic [LEN_W-1:0]         out_cnt_q;
    logic [SAT_W-1:0]         sat_count_q;
    logic                     s1_valid_q;
    logic signed [ACC_W:0]    s1_data_q;
    logic                     s2_valid_q;
    logic [OUT_W-1:0]         s2_data_q;

    logic                     run;
    logic [AW:0]              fifo_count;
    logic [AW+1:0]            occupancy;
    logic                     accept;
    logic                     out_fire;
    logic                     last_out;
    logic signed [ACC_W:0]    sum;
    logic signed [ACC_W:0]    act;
    calc_t                    rounded;
    logic                     s2_sat;
    logic [OUT_W-1:0]         s2_next;

    assign run = (state_q == StRun);

    // Credit check counts results still in flight so the FIFO can never overflow.
    assign occupancy = (AW+2)'(fifo_count) + (AW+2)'(s1_valid_q) + (AW+2)'(s2_valid_q);
    assign in_ready  = run && !start_signal && (occupancy < (AW+2)'(FIFO_DEPTH))
                       && (acc_cnt_q < len_q);
    assign accept    = in_valid && in_ready;

    assign out_valid   = (fifo_count != '0);
    assign out_fire    = out_valid && out_ready;
    assign last_out    = ((out_cnt_q + LEN_W'(1)) == len_q);
    assign done_signal = run && !start_signal && ((len_q == '0) || (out_fire && last_out));
    assign busy        = run;
    assign sat_count   = sat_count_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_signal) state_d = StRun;
            StRun: begin
                if (start_signal)     state_d = StRun;
                else if (done_signal) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        sum = (ACC_W+1)'($signed(in_data)) + (ACC_W+1)'($signed(bias_q));
        act = sum;
        case (mode_q)
            ACT_RELU:  act = sum[ACC_W] ? '0 : sum;
            ACT_LEAKY: act = sum[ACC_W] ? (sum >>> LEAKY_SHIFT) : sum;
            default:   act = sum;
        endcase
    end

    always_comb begin
        rounded = round_shift(calc_t'(s1_data_q), 32'(shift_q));
        s2_sat  = is_sat(rounded, OUT_W);
        s2_next = OUT_W'(saturate(rounded, OUT_W));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            mode_q      <= ACT_BYPASS;
            bias_q      <= '0;
            shift_q     <= '0;
            len_q       <= '0;
            acc_cnt_q   <= '0;
            out_cnt_q   <= '0;
            sat_count_q <= '0;
            s1_valid_q  <= 1'b0;
            s1_data_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_data_q   <= '0;
        end else begin
            state_q <= state_d;
            if (start_signal) begin
                mode_q      <= act_mode_e'(mode);
                bias_q      <= bias;
                shift_q     <= shift;
                len_q       <= frame_len;
                acc_cnt_q   <= '0;
                out_cnt_q   <= '0;
                sat_count_q <= '0;
                s1_valid_q  <= 1'b0;
                s2_valid_q  <= 1'b0;
            end else begin
                s1_valid_q <= accept;
                if (accept) begin
                    s1_data_q <= act;
                    acc_cnt_q <= acc_cnt_q + LEN_W'(1);
                end
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_data_q <= s2_next;
                    if (s2_sat && (sat_count_q != '1)) begin
                        sat_count_q <= sat_count_q + SAT_W'(1);
                    end
                end
                if (out_fire) out_cnt_q <= out_cnt_q + LEN_W'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush   (start_signal),
        .wr_en   (s2_valid_q && !start_signal),
        .wr_data (s2_data_q),
        .rd_en   (out_fire),
        .rd_data (out_data),
        .count   (fifo_count)
    );

endmodule

// File: tb/tb_conv_act_requant.sv
// Directed bench for conv_act_requant: activation modes, requant, backpressure, abort, reset.
module tb_conv_act_requant;

    localparam int unsigned ACC_W   = 22;
    localparam int unsigned OUT_W   = 8;
    localparam int unsigned SHIFT_W = 5;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned SAT_W   = 16;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start_signal = 1'b0;
    logic [1:0]         mode = '0;
    logic [ACC_W-1:0]   bias = '0;
    logic [SHIFT_W-1:0] shift = '0;
    logic [LEN_W-1:0]   frame_len = '0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [ACC_W-1:0]   in_data = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [OUT_W-1:0]   out_data;
    logic               done_signal;
    logic               busy;
    logic [SAT_W-1:0]   sat_count;

    int n_total = 0;
    int n_bad   = 0;
    int in_q[$];
    int exp_q[$];

    always #5 clk = ~clk;

    conv_act_requant #(
        .ACC_W       (ACC_W),
        .OUT_W       (OUT_W),
        .SHIFT_W     (SHIFT_W),
        .LEAKY_SHIFT (3),
        .FIFO_DEPTH  (4),
        .LEN_W       (LEN_W),
        .SAT_W       (SAT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_signal (start_signal),
        .mode         (mode),
        .bias         (bias),
        .shift        (shift),
        .frame_len    (frame_len),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .done_signal  (done_signal),
        .busy         (busy),
        .sat_count    (sat_count)
    );

    task automatic check_eq(input string tag, input int got, input int exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start with a config, then scramble the config inputs to prove they are ignored.
    task automatic do_start(input logic [1:0] m, input int b, input int s, input int len);
        mode         = m;
        bias         = ACC_W'(b);
        shift        = SHIFT_W'(s);
        frame_len    = LEN_W'(len);
        start_signal = 1'b1;
        @(posedge clk); #1;
        start_signal = 1'b0;
        mode         = 2'b10;
        bias         = ACC_W'(777);
        shift        = SHIFT_W'(7);
        frame_len    = LEN_W'(2);
    endtask

    // Feed in_q, collect outputs against exp_q. hold: cycles of out_ready=0 first.
    // abort_after > 0: return once that many outputs have been taken.
    task automatic stream(input string tag, input int hold, input int abort_after,
                          input int exp_sat);
        int ii = 0;
        int oo = 0;
        int dones = 0;
        int extra = 0;
        bit stop = 0;
        bit acc;
        bit hs;
        for (int cyc = 0; cyc < 300 && !stop; cyc++) begin
            in_valid = (ii < in_q.size());
            in_data  = '0;
            if (in_valid) in_data = ACC_W'(in_q[ii]);
            out_ready = (cyc >= hold);
            @(negedge clk);
            acc = in_valid && in_ready;
            hs  = out_valid && out_ready;
            if (hs) begin
                if (oo < exp_q.size())
                    check_eq($sformatf("%s out%0d", tag, oo), int'($signed(out_data)), exp_q[oo]);
                else
                    check_eq($sformatf("%s overrun", tag), oo, exp_q.size() - 1);
            end
            if (done_signal) begin
                dones++;
                check_eq({tag, " done on last hs"}, int'(hs && (oo == exp_q.size() - 1)), 1);
            end
            if (hold > 0 && cyc == hold - 1) begin
                check_eq({tag, " accepted while stalled"}, ii + int'(acc), 4);
                check_eq({tag, " in_ready while stalled"}, int'(in_ready), 0);
            end
            @(posedge clk); #1;
            if (acc) ii++;
            if (hs) oo++;
            if (abort_after > 0 && oo == abort_after) stop = 1;
            if (oo == exp_q.size()) stop = 1;
        end
        in_valid = 1'b0;
        if (abort_after > 0) begin
            check_eq({tag, " outputs before abort"}, oo, abort_after);
            check_eq({tag, " no done before abort"}, dones, 0);
        end else begin
            check_eq({tag, " output count"}, oo, exp_q.size());
            check_eq({tag, " done pulses"}, dones, 1);
            check_eq({tag, " busy after done"}, int'(busy), 0);
            check_eq({tag, " sat_count"}, int'(sat_count), exp_sat);
            repeat (3) begin
                @(negedge clk);
                if (out_valid || done_signal) extra++;
            end
            @(posedge clk); #1;
            check_eq({tag, " quiet after frame"}, extra, 0);
            check_eq({tag, " sat_count held"}, int'(sat_count), exp_sat);
        end
    endtask

    initial begin
        int seen;

        #1;
        check_eq("reset out_valid", int'(out_valid), 0);
        check_eq("reset in_ready", int'(in_ready), 0);
        check_eq("reset out_data", int'(out_data), 0);
        check_eq("reset done", int'(done_signal), 0);
        check_eq("reset busy", int'(busy), 0);
        check_eq("reset sat_count", int'(sat_count), 0);
        #12 rst = 1'b1;
        @(posedge clk); #1;

        in_valid = 1'b1;
        in_data  = ACC_W'(5);
        @(negedge clk);
        check_eq("idle in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;

        // ReLU: -5,0,7,200 -> 0,0,7,127
        in_q = '{-5, 0, 7, 200}; exp_q = '{0, 0, 7, 127};
        do_start(2'b01, 0, 0, 4);
        check_eq("busy after start", int'(busy), 1);
        stream("relu", 0, 0, 1);

        // Leaky, bias 10: -64>>>3=-8, -1>>>3=-1, -10>>>3=-2
        in_q = '{-74, -11, -20}; exp_q = '{-8, -1, -2};
        do_start(2'b10, 10, 0, 3);
        stream("leaky", 0, 0, 0);

        // Bypass, shift 2: (6+2)>>2=2, (-6+2)>>>2=-1, 1002>>2=250 -> 127
        in_q = '{6, -6, 1000}; exp_q = '{2, -1, 127};
        do_start(2'b00, 0, 2, 3);
        stream("bypass", 0, 0, 1);

        // Mode 11, bias -3, shift 1: 3->2, -3->-1, -303->-151 clamp -128, 257->129 clamp 127
        in_q = '{6, 0, -300, 260}; exp_q = '{2, -1, -128, 127};
        do_start(2'b11, -3, 1, 4);
        stream("round", 0, 0, 2);

        // Backpressure: 4 credits only, then all 10 drain in order
        in_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10}; exp_q = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
        do_start(2'b00, 0, 0, 10);
        stream("bp", 20, 0, 0);

        // Frame of 5 with continuous ready
        in_q = '{10, 20, 30, 40, 50}; exp_q = '{10, 20, 30, 40, 50};
        do_start(2'b01, 0, 0, 5);
        stream("len5", 0, 0, 0);

        // Abort after 3 outputs, then a fresh frame of 5
        in_q = '{1, 2, 3, 200, 5}; exp_q = '{1, 2, 3, 127, 5};
        do_start(2'b00, 0, 0, 5);
        stream("abort", 0, 3, 0);
        in_q = '{-1, 2, -3, 4, 5}; exp_q = '{0, 2, 0, 4, 5};
        do_start(2'b01, 0, 0, 5);
        check_eq("flush out_valid", int'(out_valid), 0);
        check_eq("restart sat_count", int'(sat_count), 0);
        stream("restart", 0, 0, 0);

        // frame_len 0: done the cycle after start, nothing accepted
        do_start(2'b00, 0, 0, 0);
        in_valid = 1'b1;
        #1;
        check_eq("len0 done", int'(done_signal), 1);
        check_eq("len0 in_ready", int'(in_ready), 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("len0 done once", int'(done_signal), 0);
        check_eq("len0 busy", int'(busy), 0);

        // Asynchronous reset mid-frame
        do_start(2'b01, 0, 0, 6);
        in_valid  = 1'b1;
        in_data   = ACC_W'(500);
        out_ready = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check_eq("pre-reset sat_count", int'(sat_count), 4);
        check_eq("pre-reset out_data", int'($signed(out_data)), 127);
        #2 rst = 1'b0;
        #1;
        check_eq("async rst out_valid", int'(out_valid), 0);
        check_eq("async rst out_data", int'(out_data), 0);
        check_eq("async rst busy", int'(busy), 0);
        check_eq("async rst in_ready", int'(in_ready), 0);
        check_eq("async rst sat_count", int'(sat_count), 0);
        #10 rst = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid || in_ready || done_signal) seen++;
        end
        check_eq("no activity after reset", seen, 0);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
